// File: rtl/fetch_stage_pq.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue for variable-latency memories.
// Sequential fetch with credit-based issue, EX redirect squashing, and decode stall/flush.
module fetch_stage_pq #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall_d,
   input  logic            flush_d,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic [XLEN-1:0] instr_d,
   output logic [XLEN-1:0] pc_d,
   output logic [XLEN-1:0] pc_plus4_d,
   output logic            valid_d
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);

   logic [XLEN-1:0] fetchPc, respPc;
   logic [CW-1:0]   count, outstanding, dropCnt;
   logic [PW-1:0]   wrPtr, rdPtr;
   logic [XLEN-1:0] pcMem    [DEPTH];
   logic [XLEN-1:0] instrMem [DEPTH];

   logic [CW:0]     inUse;
   logic            reqFire, dropResp, push, pop;
   logic [XLEN-1:0] target;

   // Every queued entry and every in-flight request holds a credit, so a
   // returning response always has a free slot.
   assign inUse          = {1'b0, count} + {1'b0, outstanding};
   assign imem_req_valid = !rst && !redirect_valid && (inUse < DEPTH_W);
   assign imem_req_addr  = fetchPc;
   assign reqFire        = imem_req_valid && imem_req_ready;
   assign dropResp       = imem_resp_valid && (dropCnt != '0);
   assign push           = imem_resp_valid && !redirect_valid && (dropCnt == '0);
   assign pop            = !redirect_valid && !flush_d && !stall_d && (count != '0);
   assign target         = redirect_pc & ~XLEN'(3);

   always_ff @(posedge clk) begin
      if (push) begin
         pcMem[wrPtr]    <= respPc;
         instrMem[wrPtr] <= imem_resp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetchPc     <= RESET_PC;
         respPc      <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         dropCnt     <= '0;
         wrPtr       <= '0;
         rdPtr       <= '0;
      end else begin
         outstanding <= outstanding + CW'(reqFire) - CW'(imem_resp_valid);
         if (redirect_valid) begin
            // Whatever is still in flight after this cycle belongs to the old path.
            fetchPc <= target;
            respPc  <= target;
            dropCnt <= outstanding - CW'(imem_resp_valid);
            count   <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
         end else begin
            if (reqFire)  fetchPc <= fetchPc + XLEN'(4);
            if (dropResp) dropCnt <= dropCnt - CW'(1);
            if (push) begin
               respPc <= respPc + XLEN'(4);
               wrPtr  <= wrPtr + PW'(1);
            end
            if (pop) rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || redirect_valid || flush_d) begin
         valid_d    <= 1'b0;
         instr_d    <= '0;
         pc_d       <= '0;
         pc_plus4_d <= '0;
      end else if (!stall_d) begin
         if (count != '0) begin
            valid_d    <= 1'b1;
            instr_d    <= instrMem[rdPtr];
            pc_d       <= pcMem[rdPtr];
            pc_plus4_d <= pcMem[rdPtr] + XLEN'(4);
         end else begin
            valid_d    <= 1'b0;
            instr_d    <= '0;
            pc_d       <= '0;
            pc_plus4_d <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push && !pop) begin
         assert (count != FULL);
      end
   end

endmodule

// File: tb/tb_fetch_stage_pq.sv
// Directed bench for fetch_stage_pq: in-order memory model, expected-PC scoreboard,
// and a forked monitor that checks each new IF/ID instruction against the queue head.
module tb_fetch_stage_pq;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall_d;
   logic        flush_d;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic        valid_d;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] sbQ[$];

   // Memory model: accepts while the bench grants budget, answers in order.
   logic        readyEn = 1'b1;
   logic        respEn  = 1'b1;
   int          reqLimit = 0;
   int          acceptCnt = 0;
   logic [31:0] memAddr [16];
   logic [3:0]  memHead = '0;
   logic [3:0]  memTail = '0;

   logic        stallPrev = 1'b0;
   logic        rstPrev   = 1'b1;
   int          startCnt;

   always #5 clk = ~clk;

   fetch_stage_pq #(
      .XLEN     (32),
      .RESET_PC (32'hFFFF_FFF8),
      .DEPTH    (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .stall_d         (stall_d),
      .flush_d         (flush_d),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr_d         (instr_d),
      .pc_d            (pc_d),
      .pc_plus4_d      (pc_plus4_d),
      .valid_d         (valid_d)
   );

   assign imem_req_ready  = readyEn && (acceptCnt < reqLimit);
   assign imem_resp_valid = respEn && (memHead != memTail);
   assign imem_resp_data  = memAddr[memHead] ^ 32'h0000_00A5;

   always @(posedge clk) begin
      if (rst) begin
         memHead <= '0;
         memTail <= '0;
      end else begin
         if (imem_resp_valid) memHead <= memHead + 4'd1;
         if (imem_req_valid && imem_req_ready) begin
            memAddr[memTail] <= imem_req_addr;
            memTail          <= memTail + 4'd1;
            acceptCnt        <= acceptCnt + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic expectSeq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) sbQ.push_back(start + 32'(4 * i));
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (sbQ.size() != 0 && k < 80) begin
         tick();
         k++;
      end
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("FAIL %s_drain actual=%0d_left required=0_left", name, sbQ.size());
         sbQ.delete();
      end
      repeat (4) tick();
   endtask

   // A new IF/ID value exists only if the previous edge was not a stall or reset edge.
   task automatic monitor();
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rstPrev && !stallPrev && valid_d) begin
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual=pc_%h required=none", pc_d);
            end else begin
               e = sbQ.pop_front();
               $display("decode pc=%h instr=%h", pc_d, instr_d);
               checkEq("pc_d", pc_d, e);
               checkEq("instr_d", instr_d, e ^ 32'h0000_00A5);
               checkEq("pc_plus4_d", pc_plus4_d, e + 32'd4);
            end
         end
         stallPrev = stall_d;
         rstPrev   = rst;
      end
   endtask

   initial begin
      fork
         monitor();
      join_none

      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; stall_d = 1'b0; flush_d = 1'b0;
      repeat (3) tick();
      checkEq("rst_valid_d", 32'(valid_d), 32'd0);
      checkEq("rst_pc_d", pc_d, 32'd0);
      checkEq("rst_instr_d", instr_d, 32'd0);
      checkEq("rst_pc_plus4_d", pc_plus4_d, 32'd0);
      checkEq("rst_req_valid", 32'(imem_req_valid), 32'd0);

      // 1: back-to-back stream from RESET_PC, wrapping through zero
      expectSeq(32'hFFFF_FFF8, 6);
      reqLimit = acceptCnt + 6;
      rst = 1'b0;
      repeat (8) tick();
      checkEq("b2b_valid_d", 32'(valid_d), 32'd1);
      checkEq("b2b_pc_d", pc_d, 32'h0000_000C);
      drain("stream");

      // 2: ready low for 5 cycles, address must hold
      readyEn = 1'b0;
      reqLimit = acceptCnt + 4;
      expectSeq(32'h0000_0010, 4);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkEq("hold_req_valid", 32'(imem_req_valid), 32'd1);
         checkEq("hold_req_addr", imem_req_addr, 32'h0000_0010);
      end
      readyEn = 1'b1;
      drain("ready_hold");

      // 3: stalled decode, credits cap issue at DEPTH
      startCnt = acceptCnt;
      reqLimit = acceptCnt + 8;
      stall_d = 1'b1;
      expectSeq(32'h0000_0020, 8);
      repeat (10) tick();
      checkEq("credit_req_valid", 32'(imem_req_valid), 32'd0);
      checkEq("credit_issued", 32'(acceptCnt - startCnt), 32'd4);
      stall_d = 1'b0;
      drain("credit");

      // 4: three in flight, then redirect to 0x100 (low bits ignored)
      respEn = 1'b0;
      reqLimit = acceptCnt + 3;
      repeat (5) tick();
      checkEq("inflight_issued", 32'(acceptCnt - reqLimit), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      checkEq("redirect_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
      redirect_pc = '0;
      reqLimit = acceptCnt + 3;
      respEn = 1'b1;
      expectSeq(32'h0000_0100, 3);
      drain("redirect");

      // 5: stall and flush together insert a bubble without popping the head
      reqLimit = acceptCnt + 4;
      stall_d = 1'b1;
      expectSeq(32'h0000_010C, 4);
      repeat (8) tick();
      stall_d = 1'b0;
      tick();
      checkEq("pre_flush_pc_d", pc_d, 32'h0000_010C);
      stall_d = 1'b1;
      flush_d = 1'b1;
      tick();
      checkEq("flush_valid_d", 32'(valid_d), 32'd0);
      checkEq("flush_pc_d", pc_d, 32'd0);
      flush_d = 1'b0;
      stall_d = 1'b0;
      drain("flush");

      // 6: mid-stream reset, restart from RESET_PC
      reqLimit = acceptCnt + 6;
      expectSeq(32'h0000_011C, 2);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      checkEq("mid_rst_valid_d", 32'(valid_d), 32'd0);
      checkEq("mid_rst_pc_d", pc_d, 32'd0);
      checkEq("mid_rst_instr_d", instr_d, 32'd0);
      checkEq("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      checkEq("mid_rst_left", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
      rst = 1'b0;
      reqLimit = acceptCnt + 4;
      expectSeq(32'hFFFF_FFF8, 4);
      drain("restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
